// File: rtl/top_tdr_creation_tessent_data_mux_ovr_if.sv
// Bundle of the override mux's data, control and status signals.
// Port summary: select/mask/functional/TDR data/capture enable flow into
// the mux; data_out/captured_data/ijtag_active/switching flow back out.
interface top_tdr_creation_tessent_data_mux_ovr_if #(
  parameter int WIDTH = 8
);
  logic             ijtag_select;
  logic [WIDTH-1:0] ijtag_bit_mask;
  logic [WIDTH-1:0] functional_data_in;
  logic [WIDTH-1:0] ijtag_data_in;
  logic             ijtag_capture_en;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] captured_data;
  logic             ijtag_active;
  logic             switching;

  // Driver side: the TDR / functional logic feeding the mux.
  modport master (
    output ijtag_select,
    output ijtag_bit_mask,
    output functional_data_in,
    output ijtag_data_in,
    output ijtag_capture_en,
    input  data_out,
    input  captured_data,
    input  ijtag_active,
    input  switching
  );

  // Mux side.
  modport slave (
    input  ijtag_select,
    input  ijtag_bit_mask,
    input  functional_data_in,
    input  ijtag_data_in,
    input  ijtag_capture_en,
    output data_out,
    output captured_data,
    output ijtag_active,
    output switching
  );
endinterface

// File: rtl/top_tdr_creation_tessent_data_mux_ovr.sv
// Registered IJTAG override mux between a TDR and functional logic, with a
// freeze window on every mode change and a raw functional capture register.
// Latency: 1 cycle steady state; mode change shows the new source HOLD_CYCLES
// edges after select is sampled. No backpressure: data is accepted every cycle.
//
// Ports: ijtag_tck (clock), ijtag_reset (sync, active-low), bus (slave modport:
// select, bit mask, functional/TDR data, capture enable in; data_out,
// captured_data, ijtag_active, switching out). Everything is in the ijtag_tck domain.
module top_tdr_creation_tessent_data_mux_ovr #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                                         ijtag_tck,
  input  logic                                         ijtag_reset,
  top_tdr_creation_tessent_data_mux_ovr_if.slave       bus
);

  // Counter must hold HOLD_CYCLES-1; keep at least one bit so HOLD_CYCLES=0
  // still elaborates (the counter is simply never loaded with anything but 0).
  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam bit NO_HOLD = (HOLD_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_FUNC     = 2'd0,
    ST_TO_IJTAG = 2'd1,
    ST_IJTAG    = 2'd2,
    ST_TO_FUNC  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  captured_q;
  logic              active_q;
  logic              switching_q;

  logic              sel;
  logic [WIDTH-1:0]  func_dat;
  logic [WIDTH-1:0]  ovr_dat;

  assign sel      = bus.ijtag_select;
  assign func_dat = bus.functional_data_in;

  // Per-bit override: masked bits come from the TDR, the rest stay functional.
  assign ovr_dat = (bus.ijtag_bit_mask & bus.ijtag_data_in) |
                   (~bus.ijtag_bit_mask & func_dat);

  // Single FSM process. Outputs are assigned together with the state they
  // belong to, so data_out and the flags always reflect the state just entered.
  // TO_* states deliberately never touch data_q: that is the freeze window.
  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      state       <= ST_FUNC;
      cnt         <= '0;
      data_q      <= '0;
      captured_q  <= '0;
      active_q    <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      // Capture is independent of the mux state and samples the raw input.
      if (bus.ijtag_capture_en) begin
        captured_q <= func_dat;
      end

      case (state)
        ST_FUNC: begin
          if (!sel) begin
            data_q      <= func_dat;
            active_q    <= 1'b0;
            switching_q <= 1'b0;
          end else if (NO_HOLD) begin
            state       <= ST_IJTAG;
            data_q      <= ovr_dat;
            active_q    <= 1'b1;
            switching_q <= 1'b0;
          end else begin
            state       <= ST_TO_IJTAG;
            cnt         <= HOLD_RELOAD;
            active_q    <= 1'b0;
            switching_q <= 1'b1;
          end
        end

        ST_TO_IJTAG: begin
          if (sel) begin
            if (cnt == '0) begin
              state       <= ST_IJTAG;
              data_q      <= ovr_dat;
              active_q    <= 1'b1;
              switching_q <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end else begin
            // Select dropped mid-transition: restart a full freeze back to FUNC.
            state       <= ST_TO_FUNC;
            cnt         <= HOLD_RELOAD;
            active_q    <= 1'b0;
            switching_q <= 1'b1;
          end
        end

        ST_IJTAG: begin
          if (sel) begin
            data_q      <= ovr_dat;
            active_q    <= 1'b1;
            switching_q <= 1'b0;
          end else if (NO_HOLD) begin
            state       <= ST_FUNC;
            data_q      <= func_dat;
            active_q    <= 1'b0;
            switching_q <= 1'b0;
          end else begin
            state       <= ST_TO_FUNC;
            cnt         <= HOLD_RELOAD;
            active_q    <= 1'b0;
            switching_q <= 1'b1;
          end
        end

        ST_TO_FUNC: begin
          if (!sel) begin
            if (cnt == '0) begin
              state       <= ST_FUNC;
              data_q      <= func_dat;
              active_q    <= 1'b0;
              switching_q <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end else begin
            // Select re-asserted mid-transition: full freeze toward IJTAG.
            state       <= ST_TO_IJTAG;
            cnt         <= HOLD_RELOAD;
            active_q    <= 1'b0;
            switching_q <= 1'b1;
          end
        end

        default: begin
          state       <= ST_FUNC;
          cnt         <= '0;
          active_q    <= 1'b0;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out      = data_q;
  assign bus.captured_data = captured_q;
  assign bus.ijtag_active  = active_q;
  assign bus.switching     = switching_q;

endmodule

// File: tb/tb_top_tdr_creation_tessent_data_mux_ovr.sv
// Scoreboard bench: the driver pushes hand-computed expectations per edge,
// a monitor pops and compares them just after each rising edge.
// Two instances: HOLD_CYCLES=2 (u=0) and HOLD_CYCLES=0 (u=1), same stimulus.
module tb_top_tdr_creation_tessent_data_mux_ovr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  top_tdr_creation_tessent_data_mux_ovr_if #(.WIDTH(8)) bus0 ();
  top_tdr_creation_tessent_data_mux_ovr_if #(.WIDTH(8)) bus1 ();

  top_tdr_creation_tessent_data_mux_ovr #(.WIDTH(8), .HOLD_CYCLES(2)) u_dut0 (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .bus         (bus0.slave)
  );

  top_tdr_creation_tessent_data_mux_ovr #(.WIDTH(8), .HOLD_CYCLES(0)) u_dut1 (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .bus         (bus1.slave)
  );

  typedef struct {
    int         u;
    logic [7:0] dout;
    logic [7:0] cdat;
    logic       act;
    logic       sw;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input string field,
                     input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
    end
  endtask

  // Monitor: one expectation per rising edge while the queue has entries.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.u == 0) begin
        chk(e.name, "data_out",  bus0.data_out,              e.dout);
        chk(e.name, "captured",  bus0.captured_data,         e.cdat);
        chk(e.name, "active",    {7'd0, bus0.ijtag_active},  {7'd0, e.act});
        chk(e.name, "switching", {7'd0, bus0.switching},     {7'd0, e.sw});
      end else begin
        chk(e.name, "data_out",  bus1.data_out,              e.dout);
        chk(e.name, "captured",  bus1.captured_data,         e.cdat);
        chk(e.name, "active",    {7'd0, bus1.ijtag_active},  {7'd0, e.act});
        chk(e.name, "switching", {7'd0, bus1.switching},     {7'd0, e.sw});
      end
    end
  end

  // Apply inputs on the falling edge; expectation describes the next rising edge.
  task automatic step(input logic rst, input logic sel, input logic [7:0] mask,
                      input logic [7:0] ijd, input logic [7:0] fin, input logic cap,
                      input int u, input logic [7:0] edo, input logic [7:0] ecd,
                      input logic eact, input logic esw, input string name);
    exp_t e;
    @(negedge clk);
    rst_n = rst;
    bus0.ijtag_select = sel;  bus1.ijtag_select = sel;
    bus0.ijtag_bit_mask = mask;  bus1.ijtag_bit_mask = mask;
    bus0.ijtag_data_in = ijd;  bus1.ijtag_data_in = ijd;
    bus0.functional_data_in = fin;  bus1.functional_data_in = fin;
    bus0.ijtag_capture_en = cap;  bus1.ijtag_capture_en = cap;
    e.u = u; e.dout = edo; e.cdat = ecd; e.act = eact; e.sw = esw; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.ijtag_select = 1'b0;  bus1.ijtag_select = 1'b0;
    bus0.ijtag_bit_mask = 8'h00;  bus1.ijtag_bit_mask = 8'h00;
    bus0.ijtag_data_in = 8'h00;  bus1.ijtag_data_in = 8'h00;
    bus0.functional_data_in = 8'h00;  bus1.functional_data_in = 8'h00;
    bus0.ijtag_capture_en = 1'b0;  bus1.ijtag_capture_en = 1'b0;

    //    rst sel mask   ijd    fin    cap u  dout   cdat   act   sw
    // Reset, then functional pass-through (mask ignored outside IJTAG).
    step(0, 0, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, "rst_1");
    step(0, 0, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, "rst_2");
    step(1, 0, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'h5A, 8'h00, 0, 0, "func_first");
    // FUNC -> IJTAG with a two-edge freeze.
    step(1, 1, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'h5A, 8'h00, 0, 1, "to_ij_hold1");
    step(1, 1, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'h5A, 8'h00, 0, 1, "to_ij_hold2");
    step(1, 1, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'hC3, 8'h00, 1, 0, "ij_enter");
    step(1, 1, 8'hFF, 8'hC3, 8'h5A, 0, 0, 8'hC3, 8'h00, 1, 0, "ij_stay");
    // Partial mask.
    step(1, 1, 8'h0F, 8'hC3, 8'h5A, 0, 0, 8'h53, 8'h00, 1, 0, "mask_0f");
    step(1, 1, 8'h0F, 8'hC3, 8'hA0, 0, 0, 8'hA3, 8'h00, 1, 0, "mask_func_a0");
    // Capture in IJTAG.
    step(1, 1, 8'h0F, 8'hC3, 8'h77, 1, 0, 8'h73, 8'h77, 1, 0, "capture");
    step(1, 1, 8'h0F, 8'hC3, 8'h11, 0, 0, 8'h13, 8'h77, 1, 0, "capture_hold");
    // IJTAG -> FUNC.
    step(1, 0, 8'h0F, 8'hC3, 8'h11, 0, 0, 8'h13, 8'h77, 0, 1, "to_func_hold1");
    step(1, 0, 8'h0F, 8'hC3, 8'h11, 0, 0, 8'h13, 8'h77, 0, 1, "to_func_hold2");
    step(1, 0, 8'h0F, 8'hC3, 8'h11, 0, 0, 8'h11, 8'h77, 0, 0, "func_back");
    // One-cycle select pulse: abort mid TO_IJTAG.
    step(1, 1, 8'h0F, 8'hC3, 8'h22, 0, 0, 8'h11, 8'h77, 0, 1, "abort_start");
    step(1, 0, 8'h0F, 8'hC3, 8'h22, 0, 0, 8'h11, 8'h77, 0, 1, "abort_edge");
    step(1, 0, 8'h0F, 8'hC3, 8'h22, 0, 0, 8'h11, 8'h77, 0, 1, "abort_hold");
    step(1, 0, 8'h0F, 8'hC3, 8'h22, 0, 0, 8'h22, 8'h77, 0, 0, "abort_done");
    // Reset during TO_IJTAG.
    step(1, 1, 8'h0F, 8'hC3, 8'h22, 0, 0, 8'h22, 8'h77, 0, 1, "pre_rst_toij");
    step(0, 1, 8'h0F, 8'hC3, 8'h22, 0, 0, 8'h00, 8'h00, 0, 0, "rst_mid");
    step(1, 0, 8'h0F, 8'hC3, 8'h44, 0, 0, 8'h44, 8'h00, 0, 0, "post_rst");
    // HOLD_CYCLES=0 instance: immediate switch, no switching flag.
    step(1, 0, 8'hFF, 8'hC3, 8'h44, 0, 1, 8'h44, 8'h00, 0, 0, "h0_func");
    step(1, 1, 8'hFF, 8'hC3, 8'h44, 0, 1, 8'hC3, 8'h00, 1, 0, "h0_ijtag");
    step(1, 1, 8'hFF, 8'h3C, 8'h44, 0, 1, 8'h3C, 8'h00, 1, 0, "h0_ijtag_3c");
    step(1, 0, 8'hFF, 8'h3C, 8'h44, 0, 1, 8'h44, 8'h00, 0, 0, "h0_func_back");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
